// File: rtl/regfile_pkg.sv
// regfile_pkg: register file geometry and writeback requester ids shared by the write arbiter.
package regfile_pkg;

    localparam int NUM_REGS   = 16;
    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 32;

    typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_e;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_ADDR_W-1:0] r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_wr_fifo.sv
// wr_fifo: per-requester writeback queue (rd + data) with count, head outputs and
// a mask of destination registers held by valid entries.
module wr_fifo
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic [REG_ADDR_W-1:0]   rd_i,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    pop_i,
    output logic                    ready_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [REG_ADDR_W-1:0]   head_rd_o,
    output logic [DATA_W-1:0]       head_data_o,
    output logic [NUM_REGS-1:0]     busy_o
);

    localparam int AW = $clog2(DEPTH);

    logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
    logic [DATA_W-1:0]     data_q [DEPTH];
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [AW:0]           count_q, count_d;
    logic                  do_push, do_pop;

    assign ready_o     = count_q < (AW+1)'(DEPTH);
    assign do_push     = push_i && ready_o;
    assign do_pop      = pop_i && (count_q != '0);
    assign count_d     = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign count_o     = count_q;
    assign head_rd_o   = rd_q[rptr_q];
    assign head_data_o = data_q[rptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_q + AW'(do_push);
            rptr_q  <= rptr_q + AW'(do_pop);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries outside the valid window are never observed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            rd_q[wptr_q]   <= rd_i;
            data_q[wptr_q] <= data_i;
        end
    end

    always_comb begin
        logic [AW-1:0] off;
        busy_o = '0;
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rptr_q;
            if ({1'b0, off} < count_q) busy_o |= onehot(rd_q[i]);
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin merge of ALU (A) and load (B) writebacks onto the
// registered register-file write port; REGFILE_WR_ARB_FIXED_PRIO_EN makes B win every tie.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0]     a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [REG_ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0]     b_data,
    output logic                  b_ready,
    output logic [DATA_W-1:0]     PW,
    output logic [REG_ADDR_W-1:0] RW,
    output logic                  E,
    output logic [NUM_REGS-1:0]   busy
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]             a_cnt, b_cnt;
    logic [REG_ADDR_W-1:0]   a_hrd, b_hrd;
    logic [DATA_W-1:0]       a_hdata, b_hdata;
    logic [NUM_REGS-1:0]     a_busy, b_busy;
    logic                    a_has, b_has, grant_a, grant_b;
    logic                    e_q, e_d;
    logic [REG_ADDR_W-1:0]   rw_q, rw_d;
    logic [DATA_W-1:0]       pw_q, pw_d;

    wr_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
        .clk_i(CLK), .rst_i(RESET), .push_i(a_valid), .rd_i(a_rd), .data_i(a_data),
        .pop_i(grant_a), .ready_o(a_ready), .count_o(a_cnt), .head_rd_o(a_hrd),
        .head_data_o(a_hdata), .busy_o(a_busy)
    );

    wr_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
        .clk_i(CLK), .rst_i(RESET), .push_i(b_valid), .rd_i(b_rd), .data_i(b_data),
        .pop_i(grant_b), .ready_o(b_ready), .count_o(b_cnt), .head_rd_o(b_hrd),
        .head_data_o(b_hdata), .busy_o(b_busy)
    );

    assign a_has = a_cnt != '0;
    assign b_has = b_cnt != '0;

`ifdef REGFILE_WR_ARB_FIXED_PRIO_EN
    assign grant_b = b_has;
    assign grant_a = a_has && !b_has;
`else
    req_e last_q;

    // On a tie the side that did not win last time goes; reset favours A first.
    assign grant_a = a_has && (!b_has || last_q == REQ_B);
    assign grant_b = b_has && !grant_a;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) last_q <= REQ_B;
        else if (grant_a || grant_b) last_q <= grant_a ? REQ_A : REQ_B;
    end
`endif

    always_comb begin
        e_d  = grant_a || grant_b;
        rw_d = grant_a ? a_hrd : grant_b ? b_hrd : rw_q;
        pw_d = grant_a ? a_hdata : grant_b ? b_hdata : pw_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            e_q  <= 1'b0;
            rw_q <= '0;
            pw_q <= '0;
        end else begin
            e_q  <= e_d;
            rw_q <= rw_d;
            pw_q <= pw_d;
        end
    end

    assign E    = e_q;
    assign RW   = rw_q;
    assign PW   = pw_q;
    assign busy = a_busy | b_busy | (e_q ? onehot(rw_q) : '0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed table, stream/backpressure/reset sequences and random
// traffic checked against a queue-based model of the two writeback FIFOs and write port.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 2;
`ifdef REGFILE_WR_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        CLK = 1'b0, RESET = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [3:0]  a_rd = '0, b_rd = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, E;
    logic [3:0]  RW;
    logic [31:0] PW;
    logic [15:0] busy;

    regfile_write_arbiter #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .PW(PW), .RW(RW), .E(E), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {logic [3:0] rd; logic [31:0] d;} ent_t;
    typedef struct {
        logic av; logic [3:0] ar; logic [31:0] ad;
        logic bv; logic [3:0] br; logic [31:0] bd;
        logic e; logic [3:0] rw; logic [31:0] pw; logic [15:0] bz;
    } vec_t;

    ent_t        aq[$], bq[$];
    logic        m_e = 1'b0;
    logic [3:0]  m_rw = '0;
    logic [31:0] m_pw = '0;
    bit          last_b = 1'b1;
    int          nvec = 0, nfail = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_busy();
        logic [15:0] b;
        b = m_e ? 16'(1) << m_rw : 16'h0;
        foreach (aq[i]) b |= 16'(1) << aq[i].rd;
        foreach (bq[i]) b |= 16'(1) << bq[i].rd;
        return b;
    endfunction

    // One clock of the reference: decide grant and accepts from pre-edge state, then compare.
    task automatic step(output bit acc_a, output bit acc_b);
        bit ga, gb;
        acc_a = a_valid && aq.size() < DEPTH;
        acc_b = b_valid && bq.size() < DEPTH;
        gb = bq.size() > 0 && (aq.size() == 0 || FIXED || !last_b);
        ga = aq.size() > 0 && !gb;
        m_e = ga || gb;
        if (ga) begin m_rw = aq[0].rd; m_pw = aq[0].d; aq.delete(0); last_b = 1'b0; end
        if (gb) begin m_rw = bq[0].rd; m_pw = bq[0].d; bq.delete(0); last_b = 1'b1; end
        if (acc_a) aq.push_back('{a_rd, a_data});
        if (acc_b) bq.push_back('{b_rd, b_data});
        @(posedge CLK);
        #1;
        chk("E", E, m_e);
        chk("RW", RW, m_rw);
        chk("PW", PW, m_pw);
        chk("busy", busy, m_busy());
        chk("a_ready", a_ready, aq.size() < DEPTH);
        chk("b_ready", b_ready, bq.size() < DEPTH);
    endtask

    initial begin
        vec_t tv[11];
        bit   ka, kb, saw_br0;
        int   ia, ib, guard;

        tv[0]  = '{1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 16'h0006};
        tv[1]  = '{0, 0, 0, 0, 0, 0, 1, FIXED ? 4'd2 : 4'd1, FIXED ? 32'h22 : 32'h11, 16'h0006};
        tv[2]  = '{0, 0, 0, 0, 0, 0, 1, FIXED ? 4'd1 : 4'd2, FIXED ? 32'h11 : 32'h22, FIXED ? 16'h0002 : 16'h0004};
        tv[3]  = '{0, 0, 0, 0, 0, 0, 0, FIXED ? 4'd1 : 4'd2, FIXED ? 32'h11 : 32'h22, 16'h0000};
        tv[4]  = '{1, 3, 32'hDEADBEEF, 0, 0, 0, 0, FIXED ? 4'd1 : 4'd2, FIXED ? 32'h11 : 32'h22, 16'h0008};
        tv[5]  = '{0, 0, 0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 16'h0008};
        tv[6]  = '{0, 0, 0, 0, 0, 0, 0, 3, 32'hDEADBEEF, 16'h0000};
        tv[7]  = '{1, 5, 32'h55, 0, 0, 0, 0, 3, 32'hDEADBEEF, 16'h0020};
        tv[8]  = '{1, 5, 32'h56, 0, 0, 0, 1, 5, 32'h55, 16'h0020};
        tv[9]  = '{0, 0, 0, 0, 0, 0, 1, 5, 32'h56, 16'h0020};
        tv[10] = '{0, 0, 0, 0, 0, 0, 0, 5, 32'h56, 16'h0000};

        #12;
        chk("rst_E", E, 0);
        chk("rst_RW", RW, 0);
        chk("rst_PW", PW, 0);
        chk("rst_busy", busy, 0);
        RESET = 1'b0;
        #1;
        chk("rst_a_ready", a_ready, 1);
        chk("rst_b_ready", b_ready, 1);

        // Directed tie, single write and repeated-destination busy rows.
        for (int i = 0; i < 11; i++) begin
            a_valid = tv[i].av; a_rd = tv[i].ar; a_data = tv[i].ad;
            b_valid = tv[i].bv; b_rd = tv[i].br; b_data = tv[i].bd;
            step(ka, kb);
            chk($sformatf("tv%0d_E", i), E, tv[i].e);
            chk($sformatf("tv%0d_RW", i), RW, tv[i].rw);
            chk($sformatf("tv%0d_PW", i), PW, tv[i].pw);
            chk($sformatf("tv%0d_busy", i), busy, tv[i].bz);
        end

        // Both sides stream 8 writes: the port must stay busy every cycle after the first accept.
        ia = 0; ib = 0; guard = 0;
        while ((ia < 8 || ib < 8 || aq.size() > 0 || bq.size() > 0) && guard < 100) begin
            a_valid = ia < 8; a_rd = 4'(ia);     a_data = 32'hA000_0000 + 32'(ia);
            b_valid = ib < 8; b_rd = 4'(8 + ib); b_data = 32'hB000_0000 + 32'(ib);
            step(ka, kb);
            if (ka) ia++;
            if (kb) ib++;
            guard++;
        end
        chk("stream_cycles", guard, 17);

        // A saturating while B offers 3 loads; B's held entry must survive backpressure.
        ia = 0; ib = 0; guard = 0; saw_br0 = 1'b0;
        while ((ia < 6 || ib < 3 || aq.size() > 0 || bq.size() > 0) && guard < 100) begin
            a_valid = ia < 6; a_rd = 4'(ia);      a_data = 32'hCA00_0000 + 32'(ia);
            b_valid = ib < 3; b_rd = 4'(12 + ib); b_data = 32'hCB00_0000 + 32'(ib);
            step(ka, kb);
            if (ka) ia++;
            if (kb) ib++;
            if (b_valid && !b_ready) saw_br0 = 1'b1;
            guard++;
        end
        chk("bp_done", guard < 100, 1);
        chk("bp_b_ready_low", saw_br0, !FIXED);

        // Random traffic; payload is held until accepted.
        ka = 1'b1; kb = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!a_valid || ka) begin
                a_valid = $urandom_range(0, 3) != 0; a_rd = 4'($urandom); a_data = $urandom;
            end
            if (!b_valid || kb) begin
                b_valid = $urandom_range(0, 2) != 0; b_rd = 4'($urandom); b_data = $urandom;
            end
            step(ka, kb);
        end

        // Reset with writes queued and in flight.
        a_valid = 1'b1; a_rd = 4'd7;  a_data = 32'h7777_0000;
        b_valid = 1'b1; b_rd = 4'd9;  b_data = 32'h9999_0000;
        repeat (3) step(ka, kb);
        a_valid = 1'b0; b_valid = 1'b0;
        chk("pre_rst_busy_nonzero", busy != 16'h0, 1);
        #2 RESET = 1'b1;
        #1;
        chk("midrst_E", E, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_RW", RW, 0);
        chk("midrst_PW", PW, 0);
        aq.delete(); bq.delete();
        m_e = 1'b0; m_rw = '0; m_pw = '0; last_b = 1'b1;
        @(posedge CLK);
        #1;
        chk("midrst_hold_E", E, 0);
        RESET = 1'b0;
        #1;
        chk("post_rst_a_ready", a_ready, 1);
        chk("post_rst_b_ready", b_ready, 1);
        repeat (4) step(ka, kb);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port (PW/RW/E) of the 16 x 32-bit register file between two writeback requesters: the ALU result path (requester A) and the memory-load path (requester B). Each requester has its own small FIFO with a valid/ready handshake. A round-robin arbiter drains one entry per cycle into a registered write port. The block also exports a per-register pending-write mask that the decode/stall logic uses for RAW hazard detection.

## Interface
- DATA_W, default 32: register data width.
- DEPTH, default 2: entries per requester FIFO; must be a power of two and at least 2.
- CLK in 1: clock; all state updates on the rising edge.
- RESET in 1: asynchronous, active-high reset.
- a_valid in 1: ALU writeback request.
- a_rd in 4: destination register for A.
- a_data in DATA_W: write data for A.
- a_ready out 1: A FIFO can accept an entry.
- b_valid in 1: load writeback request.
- b_rd in 4: destination register for B.
- b_data in DATA_W: write data for B.
- b_ready out 1: B FIFO can accept an entry.
- PW out DATA_W: register file write data; registered.
- RW out 4: register file write address; registered.
- E out 1: register file write enable; registered.
- busy out 16: bit i is set while any queued or in-flight write targets register i.

## Operation
- Handshake:
  - An entry is pushed on a rising edge when valid && ready.
  - ready = (FIFO count < DEPTH). It does not depend on valid or on a same-cycle pop, so a full FIFO reports ready=0 even in a cycle where it pops.
  - Holding valid high with ready low is legal. The payload must stay stable until accepted.
- Arbitration (combinational, each cycle, over the FIFO heads):
  - Neither FIFO has an entry: no grant; output register loads E=0.
  - Only one FIFO has an entry: that FIFO is granted.
  - Both FIFOs have entries: the requester not granted last time wins.
  - The last_grant flop updates only on an actual grant. Reset value is B, so A wins the first tie.
- Output register, loaded every edge:
  - On a grant: E=1, RW=head rd, PW=head data, and the granted FIFO pops.
  - No grant: E=0. RW and PW hold their previous values.
- busy = OR over all valid FIFO entries of onehot(rd), OR onehot(RW) when E=1.
- Same-register ordering between A and B is not guaranteed. Hazard logic must use busy to stall the second producer.
- FIFO pointers wrap modulo DEPTH. A push and a pop on the same FIFO in the same edge leave the count unchanged.

## Timing
- Reset values: E=0, RW=0, PW=0, busy=0, both FIFOs empty, a_ready=b_ready=1 once RESET deasserts, last_grant=B.
- Asserting RESET mid-operation flushes all queued and in-flight writes immediately. E drops asynchronously and the register file sees no further writes.
- Latency: an entry accepted at edge N, with no contention, drives E=1 during the cycle after edge N+1. The register file captures it at edge N+2.
- Throughput: one write per cycle total. Each requester is guaranteed at least one write every 2 cycles under contention.
- busy[i] sets in the cycle after the accepting edge. It clears in the cycle after the register file captures the last pending write to register i.

## Configuration
- REGFILE_WR_ARB_FIXED_PRIO_EN
  - Defined: fixed priority; B (load) always wins a tie. last_grant is not implemented.
  - Undefined: round-robin as described above.
- Handshake, latency and busy behaviour are identical in both modes.

## Structure
- Shared package regfile_pkg holds: NUM_REGS=16, REG_ADDR_W=4, REG_DATA_W=32, and the requester id enum (REQ_A, REQ_B).
- One sub-module, wr_fifo, instantiated once per requester. It has push/pop, a count, and head rd/data outputs.
- Arbiter, output register and busy logic live in the top module.

## Test plan
- Single write: A writes rd=3, data=0xDEADBEEF -> E=1, RW=3, PW=0xDEADBEEF two edges after acceptance; busy[3] set then cleared.
- Tie: A (rd=1) and B (rd=2) accepted on the same edge, round-robin build -> A written first, B on the next cycle. Fixed-priority build -> B first.
- Fairness: A and B each stream 8 writes continuously -> E stays high, grants strictly alternate A,B,A,B.
- Backpressure: B valid for 3 cycles with no pops possible (A saturating, fixed-priority off) -> b_ready=0 after DEPTH=2 accepts; the held third entry is written later, unchanged.
- Busy mask: A queues rd=5 twice -> busy[5] stays set until the second write is captured, then clears.
- Reset mid-flight: RESET asserted with 3 entries queued -> E=0 immediately, busy=0, both readies 1 after release, no stale writes appear afterwards.
